// File: rtl/fp_result_display_pkg.sv
// Shared display definitions: segment constants, display FSM states and
// digit-index width.
package disp_pkg;

   // Active-low segment words, ordered {dp,g,f,e,d,c,b,a}
   localparam logic [7:0] SEG_BLANK   = 8'hFF;
   localparam logic [7:0] SEG_DASH    = 8'hBF;
   localparam logic [7:0] SEG_DP_MASK = 8'h7F;

   // Four digits on the board
   localparam int DIGIT_W = 2;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_SHOW  = 1'b1
   } disp_state_e;

endpackage

// File: rtl/fp_result_display_if.sv
// FPU result port as seen by the display: result strobe, result word and
// page select.
interface fp_result_if;

   logic        result_valid;
   logic [31:0] result;
   logic        page_sel;

   modport master (
      output result_valid,
      output result,
      output page_sel
   );

   modport slave (
      input result_valid,
      input result,
      input page_sel
   );

endinterface

// File: rtl/fp_result_display_hex_to_seg.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module hex_to_seg (
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   // Standard hex glyphs, lowercase b and d
   always_comb begin
      seg_n = 7'h7F;
      case (nibble)
         4'h0: seg_n = 7'h40;
         4'h1: seg_n = 7'h79;
         4'h2: seg_n = 7'h24;
         4'h3: seg_n = 7'h30;
         4'h4: seg_n = 7'h19;
         4'h5: seg_n = 7'h12;
         4'h6: seg_n = 7'h02;
         4'h7: seg_n = 7'h78;
         4'h8: seg_n = 7'h00;
         4'h9: seg_n = 7'h10;
         4'hA: seg_n = 7'h08;
         4'hB: seg_n = 7'h03;
         4'hC: seg_n = 7'h46;
         4'hD: seg_n = 7'h21;
         4'hE: seg_n = 7'h06;
         4'hF: seg_n = 7'h0E;
         default: seg_n = 7'h7F;
      endcase
   end

endmodule

// File: rtl/fp_result_display.sv
// Captures the FPU result and scans one 16-bit half onto a 4-digit
// 7-segment display; the other half drives the LEDs.
module fp_result_display
   import disp_pkg::*;
#(
   parameter int SCAN_DIV = 1000
) (
   input  logic        clk,
   input  logic        rst,
   fp_result_if.slave  res_if,
   output logic [3:0]  anode,
   output logic [7:0]  seg,
   output logic [15:0] led,
   output logic        shown
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   disp_state_e        state_q, state_d;
   logic [31:0]        hold_q, hold_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIGIT_W-1:0] digit_q, digit_d;
   logic               page_q, page_d;
   logic [3:0]         anode_q, anode_d;
   logic [7:0]         seg_q, seg_d;
   logic [15:0]        led_q, led_d;
   logic               shown_q, shown_d;

   logic               wrap;
   logic [15:0]        page_half;
   logic [15:0]        other_half;
   logic [3:0]         nibble;
   logic [6:0]         hex_seg;

   assign wrap = (div_q == DIV_W'(SCAN_DIV - 1));

   // Next state: capture, FSM and free-running scan counter
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      div_d   = div_q + DIV_W'(1);
      digit_d = digit_q;
      page_d  = res_if.page_sel;
      if (res_if.result_valid) begin
         hold_d  = res_if.result;
         state_d = ST_SHOW;
      end
      if (wrap) begin
         div_d   = '0;
         digit_d = digit_q + DIGIT_W'(1);
      end
   end

   // Page mux and nibble select from the registered digit/hold/page
   always_comb begin
      page_half  = page_q ? hold_q[31:16] : hold_q[15:0];
      other_half = page_q ? hold_q[15:0]  : hold_q[31:16];
      nibble     = page_half[{digit_q, 2'b00} +: 4];
   end

   hex_to_seg u_hex_to_seg (
      .nibble (nibble),
      .seg_n  (hex_seg)
   );

   // Output word for the digit currently being scanned
   always_comb begin
      anode_d = ~(4'b0001 << digit_q);
      seg_d   = SEG_DASH;
      led_d   = '0;
      shown_d = 1'b0;
      if (state_q == ST_SHOW) begin
         seg_d   = {1'b1, hex_seg};
         // dp on the leftmost digit marks the high page
         if (page_q && (digit_q == DIGIT_W'(3))) begin
            seg_d = seg_d & SEG_DP_MASK;
         end
         led_d   = other_half;
         shown_d = 1'b1;
      end
   end

   // All state and output registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_EMPTY;
         hold_q  <= '0;
         div_q   <= '0;
         digit_q <= '0;
         page_q  <= 1'b0;
         anode_q <= 4'b1111;
         seg_q   <= SEG_BLANK;
         led_q   <= '0;
         shown_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         div_q   <= div_d;
         digit_q <= digit_d;
         page_q  <= page_d;
         anode_q <= anode_d;
         seg_q   <= seg_d;
         led_q   <= led_d;
         shown_q <= shown_d;
      end
   end

   assign anode = anode_q;
   assign seg   = seg_q;
   assign led   = led_q;
   assign shown = shown_q;

endmodule

// File: tb/tb_fp_result_display.sv
// Scoreboard bench for fp_result_display with a cycle-level reference model.
module tb_fp_result_display;

   localparam int SCAN_DIV = 4;

   typedef struct packed {
      logic [3:0]  an;
      logic [7:0]  sg;
      logic [15:0] ld;
      logic        sh;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [3:0]  anode;
   logic [7:0]  seg;
   logic [15:0] led;
   logic        shown;

   int checks;
   int errors;
   exp_t exp_q[$];

   fp_result_if res_if ();

   fp_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk    (clk),
      .rst    (rst),
      .res_if (res_if),
      .anode  (anode),
      .seg    (seg),
      .led    (led),
      .shown  (shown)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Standard hex glyphs with dp off
   function automatic logic [7:0] ref_seg(input int v);
      case (v)
         0:  return 8'hC0;  1:  return 8'hF9;  2:  return 8'hA4;  3:  return 8'hB0;
         4:  return 8'h99;  5:  return 8'h92;  6:  return 8'h82;  7:  return 8'hF8;
         8:  return 8'h80;  9:  return 8'h90;  10: return 8'h88;  11: return 8'h83;
         12: return 8'hC6;  13: return 8'hA1;  14: return 8'h86;  default: return 8'h8E;
      endcase
   endfunction

   // Reference model: k counts clock edges since reset release; the digit
   // shown at edge k is the one selected during the preceding edge interval.
   initial begin
      logic [31:0] m_hold;
      logic        m_show;
      logic        m_page;
      int          k;
      int          dig;
      int          half;
      exp_t        e;
      m_hold = 0; m_show = 0; m_page = 0; k = 0;
      forever begin
         @(posedge clk);
         if (!rst) begin
            m_hold = 0; m_show = 0; m_page = 0; k = 0;
         end else begin
            dig = (k / SCAN_DIV) % 4;
            e.an = 4'b1111;
            e.an[dig] = 1'b0;
            if (!m_show) begin
               e.sg = 8'hBF; e.ld = 16'h0; e.sh = 1'b0;
            end else begin
               half = m_page ? int'(m_hold[31:16]) : int'(m_hold[15:0]);
               e.sg = ref_seg((half >> (4 * dig)) & 15);
               if (m_page && dig == 3) e.sg[7] = 1'b0;
               e.ld = m_page ? m_hold[15:0] : m_hold[31:16];
               e.sh = 1'b1;
            end
            exp_q.push_back(e);
            if (res_if.result_valid) begin
               m_hold = res_if.result;
               m_show = 1'b1;
            end
            m_page = res_if.page_sel;
            k++;
         end
      end
   end

   // Monitor: compare the registered outputs at every falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            checks++;
            if (anode !== 4'hF || seg !== 8'hFF || led !== 16'h0 || shown !== 1'b0) begin
               errors++;
               $display("FAIL reset_hold: got anode=%b seg=%h led=%h shown=%b, need anode=1111 seg=ff led=0000 shown=0",
                        anode, seg, led, shown);
            end
         end else if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got output with no expected entry, need one entry per cycle");
         end else begin
            e = exp_q.pop_front();
            checks++;
            if (anode !== e.an || seg !== e.sg || led !== e.ld || shown !== e.sh) begin
               errors++;
               $display("FAIL display_out @%0t: got anode=%b seg=%h led=%h shown=%b, need anode=%b seg=%h led=%h shown=%b",
                        $time, anode, seg, led, shown, e.an, e.sg, e.ld, e.sh);
            end
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic strobe(input logic [31:0] v);
      @(negedge clk);
      res_if.result_valid = 1'b1;
      res_if.result       = v;
      @(negedge clk);
      res_if.result_valid = 1'b0;
      res_if.result       = $urandom;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      res_if.result_valid = 1'b0;
      res_if.result       = 32'h0;
      res_if.page_sel     = 1'b0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #21 rst = 1'b1;

      // Dashes with no result captured: two full frames plus
      cycles(40);

      // Low page, then high page of the same result
      strobe(32'h41BE_0000);
      cycles(20);
      @(negedge clk) res_if.page_sel = 1'b1;
      cycles(20);

      // Back-to-back overwrite two cycles apart
      @(negedge clk);
      res_if.result_valid = 1'b1; res_if.result = 32'h40A8_0000;
      @(negedge clk);
      res_if.result_valid = 1'b0;
      @(negedge clk);
      res_if.result_valid = 1'b1; res_if.result = 32'h4194_0000;
      @(negedge clk);
      res_if.result_valid = 1'b0;
      cycles(20);

      // Strobes at every phase of the scan counter, including the wrap cycle
      for (int off = 0; off < 2 * SCAN_DIV; off++) begin
         strobe($urandom);
         cycles(SCAN_DIV + off);
      end

      // Random strobes and page flips
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         res_if.result_valid = ($urandom_range(0, 7) == 0);
         res_if.result       = $urandom;
         if ($urandom_range(0, 15) == 0) res_if.page_sel = ~res_if.page_sel;
      end
      @(negedge clk) res_if.result_valid = 1'b0;
      cycles(10);

      // Asynchronous reset mid-frame with a result held
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      checks++;
      if (anode !== 4'hF || seg !== 8'hFF || led !== 16'h0 || shown !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got anode=%b seg=%h led=%h shown=%b, need anode=1111 seg=ff led=0000 shown=0",
                  anode, seg, led, shown);
      end
      exp_q.delete();
      cycles(2);
      #2 rst = 1'b1;
      cycles(24);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
